// File: rtl/gate_bist_checker.sv
// gate_bist_checker
// Self-test response checker for the 12-output two-input gate block.
// Steps {a,b} through 00,01,10,11, holds each vector for SETTLE_CYCLES
// clocks, samples y on the last edge of the window and compares it with
// the golden truth table. Reports pass, per-output fail mask and the
// first failing vector. All outputs come straight from registers.

module gate_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [47:0] EXPECTED      = 48'hB4AC_5396_17E8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] y,
    output logic        a,
    output logic        b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] fail_mask,
    output logic        first_fail_valid,
    output logic [1:0]  first_fail_vec
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Settle counter counts down to zero; zero marks the sampling edge.
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 32'd1);

    // Golden output column for one vector: bit k is EXPECTED[4k+idx].
    function automatic logic [11:0] golden_column(input logic [1:0] idx);
        logic [11:0] col;
        col = 12'h000;
        for (int k = 0; k < 12; k++) begin
            col[k] = EXPECTED[4*k + int'(idx)];
        end
        return col;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [11:0] r_fail_mask;
    logic        r_ff_valid;
    logic [1:0]  r_ff_vec;

    logic [1:0]  w_state;
    logic [1:0]  w_idx;
    logic [3:0]  w_cnt;
    logic        w_busy;
    logic        w_done;
    logic        w_pass;
    logic [11:0] w_fail_mask;
    logic        w_ff_valid;
    logic [1:0]  w_ff_vec;
    logic [11:0] w_mismatch;
    logic [11:0] w_mask_acc;

    assign w_mismatch = y ^ golden_column(r_idx);
    assign w_mask_acc = r_fail_mask | w_mismatch;

    // Next-state logic: accept start when idle/done, walk the vectors, then report.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_busy      = r_busy;
        w_done      = r_done;
        w_pass      = r_pass;
        w_fail_mask = r_fail_mask;
        w_ff_valid  = r_ff_valid;
        w_ff_vec    = r_ff_vec;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state     = ST_SETTLE;
                    w_idx       = 2'd0;
                    w_cnt       = CNT_RELOAD;
                    w_busy      = 1'b1;
                    w_done      = 1'b0;
                    w_pass      = 1'b0;
                    w_fail_mask = 12'h000;
                    w_ff_valid  = 1'b0;
                    w_ff_vec    = 2'd0;
                end else begin
                    w_state = r_state;
                end
            end
            ST_SETTLE: begin
                // start is deliberately not looked at here: a run cannot be disturbed.
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_fail_mask = w_mask_acc;
                    if ((w_mismatch != 12'h000) && !r_ff_valid) begin
                        w_ff_valid = 1'b1;
                        w_ff_vec   = r_idx;
                    end else begin
                        w_ff_valid = r_ff_valid;
                    end
                    if (r_idx != 2'd3) begin
                        w_idx = r_idx + 2'd1;
                        w_cnt = CNT_RELOAD;
                    end else begin
                        w_state = ST_DONE;
                        w_idx   = 2'd0;
                        w_cnt   = 4'd0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_mask_acc == 12'h000);
                    end
                end
            end
            default: begin
                w_state     = ST_IDLE;
                w_idx       = 2'd0;
                w_cnt       = 4'd0;
                w_busy      = 1'b0;
                w_done      = 1'b0;
                w_pass      = 1'b0;
                w_fail_mask = 12'h000;
                w_ff_valid  = 1'b0;
                w_ff_vec    = 2'd0;
            end
        endcase
    end

    // State and result registers; asynchronous reset discards any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 12'h000;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= 2'd0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pass      <= w_pass;
            r_fail_mask <= w_fail_mask;
            r_ff_valid  <= w_ff_valid;
            r_ff_vec    <= w_ff_vec;
        end
    end

    // The vector index doubles as the registered stimulus {a,b}.
    assign a                = r_idx[1];
    assign b                = r_idx[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign fail_mask        = r_fail_mask;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: a behavioural gate block (with injectable
// faults) drives y; predicted results are queued at start and checked
// when done rises. Instance 0 uses SETTLE_CYCLES=2, instance 1 uses 1.

module tb_gate_bist_checker;

    logic clk;
    logic rst_n;

    logic        start0, start1;
    logic [11:0] y0, y1;
    logic        a0, b0, busy0, done0, pass0, ffv0;
    logic        a1, b1, busy1, done1, pass1, ffv1;
    logic [11:0] mask0, mask1;
    logic [1:0]  ffvec0, ffvec1;
    int          fault0, fault1;

    int total;
    int bad;

    typedef struct packed {
        logic [11:0] mask;
        logic        ffv;
        logic [1:0]  vec;
        logic        pass;
    } exp_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        ffv;
        logic [1:0]  vec;
        logic [11:0] mask;
        logic [1:0]  ab;
    } obs_t;

    exp_t sb_q[$];

    // Behavioural gate block; fault 1: XOR stuck 0, 2: AND/OR swapped, 3: y[11] stuck 1.
    function automatic logic [11:0] gate_model(input logic ia, input logic ib, input int fault);
        logic [11:0] g;
        logic        t;
        g[0]  = ia & ib;
        g[1]  = ia | ib;
        g[2]  = ~(ia & ib);
        g[3]  = ~(ia | ib);
        g[4]  = ia ^ ib;
        g[5]  = ~(ia ^ ib);
        g[6]  = ~ia;
        g[7]  = ~ib;
        g[8]  = ia;
        g[9]  = ib;
        g[10] = ia & ~ib;
        g[11] = ~ia | ib;
        case (fault)
            1: g[4] = 1'b0;
            2: begin t = g[0]; g[0] = g[1]; g[1] = t; end
            3: g[11] = 1'b1;
            default: g = g;
        endcase
        return g;
    endfunction

    assign y0 = gate_model(a0, b0, fault0);
    assign y1 = gate_model(a1, b1, fault1);

    gate_bist_checker #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(mask0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
    );

    gate_bist_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t get_obs(input int which);
        obs_t o;
        if (which == 0) begin
            o.busy = busy0; o.done = done0; o.pass = pass0; o.ffv = ffv0;
            o.vec = ffvec0; o.mask = mask0; o.ab = {a0, b0};
        end else begin
            o.busy = busy1; o.done = done1; o.pass = pass1; o.ffv = ffv1;
            o.vec = ffvec1; o.mask = mask1; o.ab = {a1, b1};
        end
        return o;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else            start1 = v;
    endtask

    // Predicts results by comparing the faulty gate block against a fault-free one.
    function automatic exp_t predict(input int fault);
        exp_t        e;
        logic [11:0] m;
        logic [1:0]  vv;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            m  = gate_model(vv[1], vv[0], fault) ^ gate_model(vv[1], vv[0], 0);
            e.mask = e.mask | m;
            if ((m != 12'h000) && !e.ffv) begin
                e.ffv = 1'b1;
                e.vec = vv;
            end
        end
        e.pass = (e.mask == 12'h000);
        return e;
    endfunction

    task automatic chk_cleared(input string tag, input int which);
        obs_t o;
        o = get_obs(which);
        chk_val({tag, "_busy"}, 32'(o.busy), 32'd0);
        chk_val({tag, "_done"}, 32'(o.done), 32'd0);
        chk_val({tag, "_pass"}, 32'(o.pass), 32'd0);
        chk_val({tag, "_mask"}, 32'(o.mask), 32'd0);
        chk_val({tag, "_ffv"},  32'(o.ffv),  32'd0);
        chk_val({tag, "_vec"},  32'(o.vec),  32'd0);
        chk_val({tag, "_ab"},   32'(o.ab),   32'd0);
    endtask

    // One full run; repulse_k > 0 re-asserts start after edge repulse_k (while busy).
    task automatic run_test(input string tag, input int which, input int fault, input int repulse_k);
        int   sc;
        int   n;
        obs_t o;
        exp_t e;
        sc = (which == 0) ? 2 : 1;
        n  = 4 * sc;
        if (which == 0) fault0 = fault;
        else            fault1 = fault;
        sb_q.push_back(predict(fault));
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
        o = get_obs(which);
        chk_val({tag, "_acc_busy"}, 32'(o.busy), 32'd1);
        chk_val({tag, "_acc_done"}, 32'(o.done), 32'd0);
        chk_val({tag, "_acc_pass"}, 32'(o.pass), 32'd0);
        chk_val({tag, "_acc_mask"}, 32'(o.mask), 32'd0);
        chk_val({tag, "_acc_ffv"},  32'(o.ffv),  32'd0);
        chk_val({tag, "_acc_ab"},   32'(o.ab),   32'd0);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            set_start(which, (k == repulse_k) ? 1'b1 : 1'b0);
            o = get_obs(which);
            if (k < n) begin
                chk_val({tag, "_run_busy"}, 32'(o.busy), 32'd1);
                chk_val({tag, "_run_done"}, 32'(o.done), 32'd0);
                chk_val({tag, "_run_ab"},   32'(o.ab),   32'(k / sc));
            end else begin
                chk_val({tag, "_done"}, 32'(o.done), 32'd1);
                chk_val({tag, "_busy"}, 32'(o.busy), 32'd0);
                chk_val({tag, "_ab0"},  32'(o.ab),   32'd0);
                if (sb_q.size() == 0) begin
                    chk_val({tag, "_sb_underflow"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk_val({tag, "_pass"}, 32'(o.pass), 32'(e.pass));
                    chk_val({tag, "_mask"}, 32'(o.mask), 32'(e.mask));
                    chk_val({tag, "_ffv"},  32'(o.ffv),  32'(e.ffv));
                    chk_val({tag, "_vec"},  32'(o.vec),  32'(e.vec));
                end
            end
        end
        set_start(which, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t o;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        fault0 = 0;
        fault1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("rst0", 0);
        chk_cleared("rst1", 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean run, then known faults (each restart also exercises clearing from DONE).
        run_test("clean", 0, 0, 0);
        run_test("xor0", 0, 1, 0);
        run_test("swap", 0, 2, 0);

        // Reset during vector 10 of a failing run: everything drops at once.
        fault0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        o = get_obs(0);
        chk_val("midrun_ab", 32'(o.ab), 32'd2);
        chk_val("midrun_mask", 32'(o.mask), 32'h010);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("abort", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("abort_idle", 0);
        run_test("after_rst", 0, 0, 0);

        // start while busy is ignored; then restart from DONE with a fault.
        run_test("repulse", 0, 0, 3);
        run_test("restart", 0, 1, 0);

        // Single-cycle settle window.
        run_test("sc1_y11", 1, 3, 0);
        run_test("sc1_clean", 1, 0, 0);

        chk_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
